// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download-to-SDRAM loader.
// Holds the FSM state enum, the SDRAM page base table, bus widths and
// the page-number-to-base mapping function.
package rom_loader_pkg;

    localparam int unsigned PAGE_ADDR_BITS  = 14;
    localparam int unsigned PAGE_NUM_BITS   = 11;
    localparam int unsigned BASE_BITS       = 9;
    localparam int unsigned BOOT_ADDR_BITS  = BASE_BITS + PAGE_ADDR_BITS;
    localparam int unsigned IOCTL_ADDR_BITS = PAGE_NUM_BITS + PAGE_ADDR_BITS;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned INDEX_BITS      = 8;
    localparam int unsigned COUNT_BITS      = 16;

    // SDRAM base (upper address bits) of each 16 KB ROM page
    localparam logic [BASE_BITS-1:0] ROM_PAGE_BASE_0 = 9'h000;
    localparam logic [BASE_BITS-1:0] ROM_PAGE_BASE_1 = 9'h100;
    localparam logic [BASE_BITS-1:0] ROM_PAGE_BASE_2 = 9'h107;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_WRITE     = 2'd2
    } state_t;

    // One latched SDRAM write request
    typedef struct packed {
        logic [BOOT_ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0]      data;
    } boot_req_t;

    // Page number to SDRAM base; unmapped pages fall back to page 0's base
    function automatic logic [BASE_BITS-1:0] page_base(input logic [PAGE_NUM_BITS-1:0] page);
        logic [BASE_BITS-1:0] base;
        base = ROM_PAGE_BASE_0;
        case (page)
            PAGE_NUM_BITS'(1): base = ROM_PAGE_BASE_1;
            PAGE_NUM_BITS'(2): base = ROM_PAGE_BASE_2;
            default:           base = ROM_PAGE_BASE_0;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Host download stream plus SDRAM boot-write bus.
//   ioctl_download/index/wr/addr/dout : host -> loader
//   ioctl_wait                        : loader -> host back-pressure
//   boot_wr/boot_a/boot_dout          : loader -> SDRAM write port
interface rom_loader_if;
    import rom_loader_pkg::*;

    logic                       ioctl_download;
    logic [INDEX_BITS-1:0]      ioctl_index;
    logic                       ioctl_wr;
    logic [IOCTL_ADDR_BITS-1:0] ioctl_addr;
    logic [DATA_BITS-1:0]       ioctl_dout;
    logic                       ioctl_wait;
    logic                       boot_wr;
    logic [BOOT_ADDR_BITS-1:0]  boot_a;
    logic [DATA_BITS-1:0]       boot_dout;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, boot_wr, boot_a, boot_dout
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, boot_wr, boot_a, boot_dout
    );

endinterface

// File: rtl/rom_loader.sv
// Copies a ROM image from the host download stream into SDRAM, one byte
// per SDRAM slot, remapping each 16 KB page to its SDRAM base.
// Ports:
//   clk_sys        system clock (rising edge)
//   reset          synchronous active-high reset
//   ce_ref         one-cycle SDRAM slot strobe, every 16 clk_sys
//   bus            rom_loader_if.slave: ioctl_* in, ioctl_wait/boot_* out
//   loading        ROM download active (combinational)
//   done           one-cycle pulse once a download has ended and drained
//   bytes_written  saturating count of bytes committed to SDRAM
//   overflow       sticky: a byte was dropped (out of range or busy)
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned           PAGES      = 3,
    parameter logic [INDEX_BITS-1:0] LOAD_INDEX = 8'h00
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ce_ref,
    rom_loader_if.slave           bus,
    output logic                  loading,
    output logic                  done,
    output logic [COUNT_BITS-1:0] bytes_written,
    output logic                  overflow
);

    state_t                   state_q;
    state_t                   state_d;
    boot_req_t                req_q;
    logic                     wait_q;
    logic                     boot_wr_q;
    logic                     active;
    logic                     active_q;
    logic                     active_rise;
    logic                     active_fall;
    logic                     done_pending_q;
    logic                     done_fire;
    logic                     wr_valid;
    logic                     in_range;
    logic                     accept;
    logic                     drop;
    logic                     start_wr;
    logic                     finish_wr;
    logic [PAGE_NUM_BITS-1:0] page;

    assign active      = bus.ioctl_download & (bus.ioctl_index == LOAD_INDEX);
    assign loading     = active;
    assign active_rise = active & ~active_q;
    assign active_fall = ~active & active_q;
    assign wr_valid    = active & bus.ioctl_wr;
    assign page        = bus.ioctl_addr[IOCTL_ADDR_BITS-1:PAGE_ADDR_BITS];
    assign in_range    = (32'(page) < PAGES);

    // done waits for the FSM to be idle so an in-flight write drains first
    assign done_fire   = (active_fall | done_pending_q) & (state_q == ST_IDLE);

    assign bus.ioctl_wait = wait_q;
    assign bus.boot_wr    = boot_wr_q;
    assign bus.boot_a     = req_q.addr;
    assign bus.boot_dout  = req_q.data;

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle actions
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        drop      = 1'b0;
        start_wr  = 1'b0;
        finish_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    if (in_range) begin
                        accept  = 1'b1;
                        state_d = ST_WAIT_SLOT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_WAIT_SLOT: begin
                drop = wr_valid;
                if (ce_ref) begin
                    start_wr = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // boot_wr spans ce_ref to ce_ref: one full slot period
                drop = wr_valid;
                if (ce_ref) begin
                    finish_wr = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, request latch, counters and edge tracking
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            req_q          <= '0;
            wait_q         <= 1'b0;
            boot_wr_q      <= 1'b0;
            active_q       <= 1'b0;
            done_pending_q <= 1'b0;
            done           <= 1'b0;
            bytes_written  <= '0;
            overflow       <= 1'b0;
        end else begin
            active_q <= active;

            if (accept) begin
                req_q  <= '{addr: {page_base(page), bus.ioctl_addr[PAGE_ADDR_BITS-1:0]},
                            data: bus.ioctl_dout};
                wait_q <= 1'b1;
            end
            if (start_wr) begin
                boot_wr_q <= 1'b1;
            end
            if (finish_wr) begin
                boot_wr_q <= 1'b0;
                wait_q    <= 1'b0;
            end

            if (active_rise) begin
                bytes_written <= '0;
            end else if (finish_wr && (bytes_written != '1)) begin
                bytes_written <= bytes_written + COUNT_BITS'(1);
            end

            // A drop in the very first active cycle still counts
            overflow <= active_rise ? drop : (overflow | drop);

            done           <= done_fire;
            done_pending_q <= (active_fall | done_pending_q) & ~done_fire;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected SDRAM writes,
// a monitor pops and checks them as boot_wr pulses appear.
module tb_rom_loader;
    import rom_loader_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_ref  = 1'b0;
    logic        loading;
    logic        done;
    logic [15:0] bytes_written;
    logic        overflow;
    logic [3:0]  ce_cnt  = 4'd0;

    int checks   = 0;
    int errors   = 0;
    int n_writes = 0;
    int n_pushed = 0;
    int n_done   = 0;

    boot_req_t exp_q[$];

    rom_loader_if bus ();

    rom_loader #(
        .PAGES      (3),
        .LOAD_INDEX (8'h00)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_ref        (ce_ref),
        .bus           (bus.slave),
        .loading       (loading),
        .done          (done),
        .bytes_written (bytes_written),
        .overflow      (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM slot strobe: one cycle in sixteen
    always @(posedge clk_sys) begin
        #1;
        ce_cnt = ce_cnt + 4'd1;
        ce_ref = (ce_cnt == 4'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] exp_addr(input logic [24:0] addr);
        logic [22:0] base;
        case (addr[24:14])
            11'd1:   base = 23'h400000;
            11'd2:   base = 23'h41C000;
            default: base = 23'h000000;
        endcase
        return base | 23'(addr[13:0]);
    endfunction

    // Monitor: pop/compare on each boot_wr rise, check width/stability on fall
    bit        in_wr     = 1'b0;
    bit        prev_wr   = 1'b0;
    bit        prev_ce   = 1'b0;
    bit        wr_stable = 1'b1;
    int        wr_width  = 0;
    boot_req_t cur;
    boot_req_t exp_req;

    always @(negedge clk_sys) begin
        if (reset) begin
            in_wr   = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (bus.boot_wr && !prev_wr) begin
                n_writes++;
                check("wr_after_ce_ref", 32'(prev_ce), 32'd1);
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_req = exp_q.pop_front();
                    check("boot_a", 32'(bus.boot_a), 32'(exp_req.addr));
                    check("boot_dout", 32'(bus.boot_dout), 32'(exp_req.data));
                end
                cur       = '{addr: bus.boot_a, data: bus.boot_dout};
                in_wr     = 1'b1;
                wr_width  = 1;
                wr_stable = 1'b1;
            end else if (bus.boot_wr && in_wr) begin
                wr_width++;
                if ((bus.boot_a != cur.addr) || (bus.boot_dout != cur.data)) wr_stable = 1'b0;
            end else if (!bus.boot_wr && prev_wr && in_wr) begin
                check("boot_wr_width", 32'(wr_width), 32'd16);
                check("req_stable", 32'(wr_stable), 32'd1);
                in_wr = 1'b0;
            end
            if (done) begin
                n_done++;
                check("done_after_drain",
                      32'(!bus.boot_wr && !bus.ioctl_wait && (exp_q.size() == 0)), 32'd1);
            end
            prev_wr = bus.boot_wr;
        end
        prev_ce = ce_ref;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Present one byte for one cycle; ends at the negedge after it is sampled
    task automatic issue_wr(input logic [24:0] addr, input logic [7:0] data, input bit exp_acc);
        @(posedge clk_sys); #1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        if (exp_acc) begin
            exp_q.push_back('{addr: exp_addr(addr), data: data});
            n_pushed++;
        end
        @(posedge clk_sys); #1;
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("wait_after_wr", 32'(bus.ioctl_wait), 32'(exp_acc));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.ioctl_wait && n < 40) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            n++;
        end
        check("wait_latency", 32'(!bus.ioctl_wait && (n <= 33)), 32'd1);
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        issue_wr(addr, data, 1'b1);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [24:0] a;
        logic [7:0]  d;

        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'h00;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        check("rst_boot_wr", 32'(bus.boot_wr), 32'd0);
        check("rst_boot_a", 32'(bus.boot_a), 32'd0);
        check("rst_boot_dout", 32'(bus.boot_dout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bytes", 32'(bytes_written), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;

        // Download 1: three mapped bytes and one out-of-range byte
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("loading_on", 32'(loading), 32'd1);
        send_byte(25'h0000000, 8'hA5);
        check("bytes_after_first", 32'(bytes_written), 32'd1);
        send_byte(25'h0004001, 8'h5C);
        send_byte(25'h0008003, 8'hC3);
        issue_wr(25'h000C000, 8'h77, 1'b0);
        check("overflow_out_of_range", 32'(overflow), 32'd1);
        idle(40);
        check("wait_stays_low", 32'(bus.ioctl_wait), 32'd0);
        check("bytes_unchanged", 32'(bytes_written), 32'd3);
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b0;
        idle(4);
        check("loading_off", 32'(loading), 32'd0);
        check("done_count_1", 32'(n_done), 32'd1);

        // Download 2: rise clears stats; byte while busy is dropped
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b1;
        idle(2);
        check("rise_clears_bytes", 32'(bytes_written), 32'd0);
        check("rise_clears_overflow", 32'(overflow), 32'd0);
        issue_wr(25'h0000010, 8'h3C, 1'b1);
        @(posedge clk_sys); #1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h0000020;
        bus.ioctl_dout = 8'h99;
        @(posedge clk_sys); #1;
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("overflow_busy", 32'(overflow), 32'd1);
        wait_idle();
        check("bytes_busy_drop", 32'(bytes_written), 32'd1);
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b0;
        idle(4);
        check("done_count_2", 32'(n_done), 32'd2);

        // Download 3: stream across all pages; drop download with last byte in flight
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 32; i++) begin
                a = 25'(p * 16384 + i * 509);
                d = 8'(i * 7 + p * 3 + 1);
                if ((p == 2) && (i == 31)) issue_wr(a, d, 1'b1);
                else send_byte(a, d);
            end
        end
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("done_held_while_busy", 32'(n_done), 32'd2);
        wait_idle();
        idle(4);
        check("done_count_3", 32'(n_done), 32'd3);
        check("stream_bytes", 32'(bytes_written), 32'd96);

        // Reset during WRITE aborts the write
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b1;
        issue_wr(25'h0000100, 8'h5A, 1'b1);
        n = 0;
        while (!bus.boot_wr && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("reached_write", 32'(bus.boot_wr), 32'd1);
        repeat (3) @(posedge clk_sys);
        #1;
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("abort_boot_wr", 32'(bus.boot_wr), 32'd0);
        check("abort_wait", 32'(bus.ioctl_wait), 32'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        idle(40);
        check("no_done_after_reset", 32'(n_done), 32'd3);
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b1;
        send_byte(25'h0000002, 8'hE1);
        check("bytes_after_reset", 32'(bytes_written), 32'd1);
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b0;
        idle(4);
        check("done_count_4", 32'(n_done), 32'd4);

        // Non-ROM download index is ignored
        @(posedge clk_sys); #1;
        bus.ioctl_index    = 8'h01;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("loading_other_index", 32'(loading), 32'd0);
        issue_wr(25'h0000000, 8'h11, 1'b0);
        idle(40);
        check("bytes_other_index", 32'(bytes_written), 32'd1);
        @(posedge clk_sys); #1;
        bus.ioctl_download = 1'b0;
        idle(4);
        check("done_count_final", 32'(n_done), 32'd4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(n_writes), 32'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
